// File: rtl/rop_wmb.sv
// ============================================================================
// Module   : rop_wmb
// Brief    : ROP store write-merge buffer; FIFO drain to memory, read-hazard check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rop_wmb #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_wstrb,
  output logic        st_ready,
  output logic        mem_wr_valid,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_strb,
  input  logic        mem_wr_ready,
  input  logic [31:0] rd_chk_addr,
  output logic        rd_chk_hit,
  output logic        empty,
  output logic        busy
);

  localparam int           PW     = $clog2(DEPTH);
  localparam logic [PW:0]  C_FULL = (PW+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [29:0]      waddr_q [DEPTH];
  logic [29:0]      waddr_d [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [31:0]      data_d  [DEPTH];
  logic [3:0]       strb_q  [DEPTH];
  logic [3:0]       strb_d  [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW:0]      count_q, count_d;

  logic          w_hit, w_rd_hit, w_empty, w_full;
  logic          w_accept, w_alloc, w_merge, w_pop;
  logic [PW-1:0] w_hit_idx;
  logic [31:0]   w_byte_mask;

  // The head entry is locked for draining, so it is excluded from merge matching.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_rd_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (PW'(i) != head_q) && (waddr_q[i] == st_addr[31:2])) begin
        w_hit     = st_valid;
        w_hit_idx = PW'(i);
      end
      if (valid_q[i] && (waddr_q[i] == rd_chk_addr[31:2])) begin
        w_rd_hit = 1'b1;
      end
    end
  end

  assign w_empty  = (count_q == '0);
  assign w_full   = (count_q == C_FULL);
  assign st_ready = w_hit || !w_full;
  assign w_accept = st_valid && st_ready && (|st_wstrb) && !flush;
  assign w_merge  = w_accept && w_hit;
  assign w_alloc  = w_accept && !w_hit;
  assign w_pop    = !w_empty && mem_wr_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    waddr_d = waddr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_merge) begin
        for (int b = 0; b < 4; b++) begin
          if (st_wstrb[b]) begin
            data_d[w_hit_idx][8*b +: 8] = st_wdata[8*b +: 8];
            strb_d[w_hit_idx][b]        = 1'b1;
          end
        end
      end
      if (w_alloc) begin
        valid_d[tail_q] = 1'b1;
        waddr_d[tail_q] = st_addr[31:2];
        data_d[tail_q]  = st_wdata;
        strb_d[tail_q]  = st_wstrb;
        tail_d          = tail_q + PW'(1);
      end
      if (w_pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PW'(1);
      end
      if (w_alloc && !w_pop) begin
        count_d = count_q + (PW+1)'(1);
      end else if (w_pop && !w_alloc) begin
        count_d = count_q - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        data_q[i]  <= '0;
        strb_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
    end
  end

  // Unstrobed bytes are forced to zero so stale data never leaves the buffer.
  always_comb begin
    w_byte_mask = '0;
    for (int b = 0; b < 4; b++) begin
      w_byte_mask[8*b +: 8] = {8{strb_q[head_q][b]}};
    end
  end

  assign mem_wr_valid = !w_empty;
  assign mem_wr_addr  = w_empty ? 32'd0 : {waddr_q[head_q], 2'b00};
  assign mem_wr_data  = w_empty ? 32'd0 : (data_q[head_q] & w_byte_mask);
  assign mem_wr_strb  = w_empty ? 4'd0  : strb_q[head_q];
  assign rd_chk_hit   = w_rd_hit;
  assign empty        = w_empty;
  assign busy         = !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_rop_wmb.sv
// ============================================================================
// Module   : tb_rop_wmb
// Brief    : Directed self-checking bench for rop_wmb.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rop_wmb;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        st_ready;
  logic        mem_wr_valid;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic        mem_wr_ready;
  logic [31:0] rd_chk_addr;
  logic        rd_chk_hit;
  logic        empty;
  logic        busy;

  integer total;
  integer bad;

  rop_wmb #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_wdata     (st_wdata),
    .st_wstrb     (st_wstrb),
    .st_ready     (st_ready),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_strb  (mem_wr_strb),
    .mem_wr_ready (mem_wr_ready),
    .rd_chk_addr  (rd_chk_addr),
    .rd_chk_hit   (rd_chk_hit),
    .empty        (empty),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven 1ns after it.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    st_wstrb = s;
  endtask

  task automatic idle_store;
    st_valid = 1'b0;
    st_addr  = 32'd0;
    st_wdata = 32'd0;
    st_wstrb = 4'd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++;
    if (st_ready !== 1'b1 || mem_wr_valid !== 1'b0 || mem_wr_addr !== 32'd0 ||
        mem_wr_data !== 32'd0 || mem_wr_strb !== 4'd0 || rd_chk_hit !== 1'b0 ||
        empty !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b v=%b a=%h d=%h s=%b hit=%b e=%b b=%b required 1 0 0 0 0 0 1 0",
               st_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb, rd_chk_hit, empty, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single;
    mem_wr_ready = 1'b1;
    drive_store(32'h1000, 32'hAABBCCDD, 4'b1111);
    step();
    idle_store();
    #1;
    total++;
    if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h1000 || mem_wr_data !== 32'hAABBCCDD || mem_wr_strb !== 4'hF) begin
      bad++;
      $display("FAIL single_head: v=%b a=%h d=%h s=%b required 1 00001000 aabbccdd 1111",
               mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb);
    end
    step();
    total++;
    if (empty !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_drained: empty=%b busy=%b required 1 0", empty, busy);
    end
  endtask

  task automatic test_merge;
    mem_wr_ready = 1'b0;
    drive_store(32'h2000, 32'h00001234, 4'b0011); step();
    drive_store(32'h3000, 32'h11111111, 4'b1111); step();
    drive_store(32'h3002, 32'hBEEF0000, 4'b1100);
    #1;
    total++;
    if (st_ready !== 1'b1) begin
      bad++;
      $display("FAIL merge_ready: st_ready=%b required 1", st_ready);
    end
    step();
    idle_store();
    #1;
    total++;
    if (mem_wr_addr !== 32'h2000 || mem_wr_data !== 32'h00001234 || mem_wr_strb !== 4'b0011) begin
      bad++;
      $display("FAIL merge_head0: a=%h d=%h s=%b required 00002000 00001234 0011", mem_wr_addr, mem_wr_data, mem_wr_strb);
    end
    mem_wr_ready = 1'b1;
    step();
    total++;
    if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h3000 || mem_wr_data !== 32'hBEEF1111 || mem_wr_strb !== 4'hF) begin
      bad++;
      $display("FAIL merge_head1: v=%b a=%h d=%h s=%b required 1 00003000 beef1111 1111",
               mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb);
    end
    step();
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL merge_drained: empty=%b required 1", empty);
    end
  endtask

  task automatic test_full;
    mem_wr_ready = 1'b0;
    drive_store(32'h0, 32'h00000000, 4'hF); step();
    drive_store(32'h4, 32'h04040404, 4'hF); step();
    drive_store(32'h8, 32'h08080808, 4'hF); step();
    drive_store(32'hC, 32'h0C0C0C0C, 4'hF); step();
    drive_store(32'h10, 32'h10101010, 4'hF);
    #1;
    total++;
    if (st_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_stall: st_ready=%b required 0", st_ready);
    end
    drive_store(32'h8, 32'h00000055, 4'b0001);
    #1;
    total++;
    if (st_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_merge_ready: st_ready=%b required 1", st_ready);
    end
    step();
    drive_store(32'h10, 32'h10101010, 4'hF);
    mem_wr_ready = 1'b1;
    #1;
    total++;
    if (st_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_pop_stall: st_ready=%b required 0", st_ready);
    end
    step();
    total++;
    if (st_ready !== 1'b1 || mem_wr_addr !== 32'h4) begin
      bad++;
      $display("FAIL full_after_pop: st_ready=%b head=%h required 1 00000004", st_ready, mem_wr_addr);
    end
    step();
    idle_store();
    #1;
    total++;
    if (mem_wr_addr !== 32'h8 || mem_wr_data !== 32'h08080855) begin
      bad++;
      $display("FAIL full_merged_entry: a=%h d=%h required 00000008 08080855", mem_wr_addr, mem_wr_data);
    end
    step();
    total++;
    if (mem_wr_addr !== 32'hC || mem_wr_data !== 32'h0C0C0C0C) begin
      bad++;
      $display("FAIL full_order_c: a=%h d=%h required 0000000c 0c0c0c0c", mem_wr_addr, mem_wr_data);
    end
    step();
    total++;
    if (mem_wr_addr !== 32'h10 || mem_wr_data !== 32'h10101010) begin
      bad++;
      $display("FAIL full_order_10: a=%h d=%h required 00000010 10101010", mem_wr_addr, mem_wr_data);
    end
    step();
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL full_drained: empty=%b required 1", empty);
    end
  endtask

  task automatic test_head_lock;
    mem_wr_ready = 1'b0;
    drive_store(32'h40, 32'h00000001, 4'hF); step();
    drive_store(32'h40, 32'h00000002, 4'hF); step();
    idle_store();
    mem_wr_ready = 1'b1;
    #1;
    total++;
    if (mem_wr_addr !== 32'h40 || mem_wr_data !== 32'h1) begin
      bad++;
      $display("FAIL lock_first: a=%h d=%h required 00000040 00000001", mem_wr_addr, mem_wr_data);
    end
    step();
    total++;
    if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h40 || mem_wr_data !== 32'h2) begin
      bad++;
      $display("FAIL lock_second: v=%b a=%h d=%h required 1 00000040 00000002", mem_wr_valid, mem_wr_addr, mem_wr_data);
    end
    step();
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL lock_drained: empty=%b required 1", empty);
    end
  endtask

  task automatic test_rd_chk;
    mem_wr_ready = 1'b0;
    drive_store(32'h100, 32'hA, 4'hF); step();
    drive_store(32'h104, 32'hB, 4'hF); step();
    idle_store();
    rd_chk_addr = 32'h106;
    #1;
    total++;
    if (rd_chk_hit !== 1'b1) begin
      bad++;
      $display("FAIL rdchk_hit: rd_chk_hit=%b required 1", rd_chk_hit);
    end
    rd_chk_addr = 32'h108;
    #1;
    total++;
    if (rd_chk_hit !== 1'b0) begin
      bad++;
      $display("FAIL rdchk_miss: rd_chk_hit=%b required 0", rd_chk_hit);
    end
    mem_wr_ready = 1'b1;
    step();
    step();
    rd_chk_addr = 32'h106;
    #1;
    total++;
    if (rd_chk_hit !== 1'b0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL rdchk_drained: rd_chk_hit=%b empty=%b required 0 1", rd_chk_hit, empty);
    end
    rd_chk_addr = 32'd0;
  endtask

  task automatic test_flush_and_reset;
    mem_wr_ready = 1'b0;
    drive_store(32'h200, 32'h1, 4'hF); step();
    drive_store(32'h204, 32'h2, 4'hF); step();
    drive_store(32'h208, 32'h3, 4'hF); step();
    drive_store(32'h20C, 32'h4, 4'hF);
    flush        = 1'b1;
    mem_wr_ready = 1'b1;
    #1;
    total++;
    if (mem_wr_valid !== 1'b1) begin
      bad++;
      $display("FAIL flush_cycle_valid: mem_wr_valid=%b required 1", mem_wr_valid);
    end
    step();
    flush = 1'b0;
    idle_store();
    mem_wr_ready = 1'b0;
    #1;
    total++;
    if (empty !== 1'b1 || mem_wr_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_empty: empty=%b v=%b required 1 0", empty, mem_wr_valid);
    end
    drive_store(32'h300, 32'h5, 4'hF); step();
    drive_store(32'h304, 32'h6, 4'hF); step();
    drive_store(32'h308, 32'h7, 4'hF); step();
    idle_store();
    mem_wr_ready = 1'b1;
    step();
    rd_chk_addr = 32'h304;
    #1;
    total++;
    if (rd_chk_hit !== 1'b1 || mem_wr_addr !== 32'h304) begin
      bad++;
      $display("FAIL reset_middrain_pre: hit=%b head=%h required 1 00000304", rd_chk_hit, mem_wr_addr);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (st_ready !== 1'b1 || mem_wr_valid !== 1'b0 || mem_wr_addr !== 32'd0 ||
        mem_wr_data !== 32'd0 || mem_wr_strb !== 4'd0 || rd_chk_hit !== 1'b0 ||
        empty !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_middrain: rdy=%b v=%b a=%h d=%h s=%b hit=%b e=%b b=%b required 1 0 0 0 0 0 1 0",
               st_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb, rd_chk_hit, empty, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b1;
    flush        = 1'b0;
    mem_wr_ready = 1'b0;
    rd_chk_addr  = 32'd0;
    idle_store();
    #2;
    test_reset();
    test_single();
    test_merge();
    test_full();
    test_head_lock();
    test_rd_chk();
    test_flush_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
